// File: rtl/cordic_vector_iter.sv
// cordic_vector_iter
//   Iterative vectoring-mode CORDIC. One (x, y) pair per transaction is
//   rotated onto the positive x axis by driving y to zero, one
//   micro-rotation per clock. The residual x is the gain-scaled magnitude
//   and the accumulated z is atan2(y, x) in Q3.29 radians.
//
//   Optional build macro: GAIN_COMP_EN
//     When defined, an extra GAIN state multiplies x by 1/K (Q1.31,
//     truncated) so mag_out is the true magnitude. Latency grows by one.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, aborts any transaction
//   start      in   request, sampled only while idle
//   x_in       in   signed x operand, |x_in| <= 2^29
//   y_in       in   signed y operand, |y_in| <= 2^29
//   busy       out  high from the cycle after start is taken until done
//   done       out  one-cycle pulse, results valid on this cycle
//   mag_out    out  signed magnitude (gain-scaled unless GAIN_COMP_EN)
//   angle_out  out  signed angle, Q3.29 radians, [-pi, +pi]
module cordic_vector_iter #(
  parameter int ITER = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] mag_out,
  output logic signed [31:0] angle_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREROT  = 3'd1;
  localparam logic [2:0] S_ITERATE = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
`ifdef GAIN_COMP_EN
  localparam logic [2:0] S_GAIN    = 3'd4;
`endif

  localparam logic signed [31:0] HALF_PI = 32'sh3243F6A8;
  localparam logic [4:0]         LAST_I  = 5'(ITER - 1);

  // round(atan(2^-i) * 2^29)
  function automatic logic signed [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_rom = 32'sh1921FB54;
      5'd1:    atan_rom = 32'sh0ED63383;
      5'd2:    atan_rom = 32'sh07D6DD7E;
      5'd3:    atan_rom = 32'sh03FAB753;
      5'd4:    atan_rom = 32'sh01FF55BB;
      5'd5:    atan_rom = 32'sh00FFEAAE;
      5'd6:    atan_rom = 32'sh007FFD55;
      5'd7:    atan_rom = 32'sh003FFFAB;
      5'd8:    atan_rom = 32'sh001FFFF5;
      5'd9:    atan_rom = 32'sh000FFFFF;
      5'd10:   atan_rom = 32'sh00080000;
      5'd11:   atan_rom = 32'sh00040000;
      5'd12:   atan_rom = 32'sh00020000;
      5'd13:   atan_rom = 32'sh00010000;
      5'd14:   atan_rom = 32'sh00008000;
      5'd15:   atan_rom = 32'sh00004000;
      5'd16:   atan_rom = 32'sh00002000;
      5'd17:   atan_rom = 32'sh00001000;
      5'd18:   atan_rom = 32'sh00000800;
      5'd19:   atan_rom = 32'sh00000400;
      5'd20:   atan_rom = 32'sh00000200;
      5'd21:   atan_rom = 32'sh00000100;
      5'd22:   atan_rom = 32'sh00000080;
      5'd23:   atan_rom = 32'sh00000040;
      5'd24:   atan_rom = 32'sh00000020;
      5'd25:   atan_rom = 32'sh00000010;
      5'd26:   atan_rom = 32'sh00000008;
      5'd27:   atan_rom = 32'sh00000004;
      5'd28:   atan_rom = 32'sh00000002;
      5'd29:   atan_rom = 32'sh00000001;
      default: atan_rom = 32'sh00000000;
    endcase
  endfunction

`ifdef GAIN_COMP_EN
  // x * K^-1 with K^-1 = 0x4DBA76D4 in Q1.31; truncating >>> 31
  function automatic logic signed [31:0] gain_scale(input logic signed [31:0] v);
    logic signed [63:0] prod;
    prod = $signed({{32{v[31]}}, v}) * 64'sh000000004DBA76D4;
    gain_scale = prod[62:31];
  endfunction
`endif

  logic [2:0]         state_q, state_d;
  logic [4:0]         i_q, i_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic signed [31:0] mag_q, mag_d;
  logic signed [31:0] ang_q, ang_d;

  logic signed [31:0] x_sh, y_sh;

  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mag_d   = mag_q;
    ang_d   = ang_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = 32'sd0;
          // z accumulates nonzero atan terms even for a null vector,
          // so the result is forced to zero at the end instead
          zero_d  = (x_in == 32'sd0) && (y_in == 32'sd0);
          busy_d  = 1'b1;
          state_d = S_PREROT;
        end
      end

      S_PREROT: begin
        // fold the left half-plane into the right by +/-90 degrees;
        // y = 0 goes through +90 so the result lands on +pi, never -pi
        if (x_q[31]) begin
          if (!y_q[31]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = HALF_PI;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = -HALF_PI;
          end
        end
        i_d     = 5'd0;
        state_d = S_ITERATE;
      end

      S_ITERATE: begin
        if (y_q[31]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_rom(i_q);
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_rom(i_q);
        end
        if (i_q == LAST_I) begin
          i_d = 5'd0;
`ifdef GAIN_COMP_EN
          state_d = S_GAIN;
`else
          state_d = S_DONE;
`endif
        end else begin
          i_d = i_q + 5'd1;
        end
      end

`ifdef GAIN_COMP_EN
      S_GAIN: begin
        x_d     = gain_scale(x_q);
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        mag_d   = zero_q ? 32'sd0 : x_q;
        ang_d   = zero_q ? 32'sd0 : z_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= 5'd0;
      x_q     <= 32'sd0;
      y_q     <= 32'sd0;
      z_q     <= 32'sd0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mag_q   <= 32'sd0;
      ang_q   <= 32'sd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mag_out   = mag_q;
  assign angle_out = ang_q;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Self-checking bench for cordic_vector_iter: directed vector table,
// hand-written handshake/reset sequences, and random operands checked
// against a real-arithmetic atan2/hypot model.
module tb_cordic_vector_iter;

  localparam int ITER = 16;
`ifdef GAIN_COMP_EN
  localparam int     LAT    = ITER + 3;
  localparam longint MAG_X1 = 1048576;
  localparam longint MAG_XY = 1482910;
  localparam real    POST   = real'(32'h4DBA76D4) / 2147483648.0;
`else
  localparam int     LAT    = ITER + 2;
  localparam longint MAG_X1 = 1726775;
  localparam longint MAG_XY = 2442052;
  localparam real    POST   = 1.0;
`endif
  localparam longint A_PI   = 1686629713;  // 0x6487ED51
  localparam longint A_PI4  = 421657428;   // 0x1921FB54
  localparam longint A_PI2  = 843314856;   // 0x3243F6A8

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [31:0] x_in;
  logic signed [31:0] y_in;
  logic               busy;
  logic               done;
  logic signed [31:0] mag_out;
  logic signed [31:0] angle_out;

  int checks = 0;
  int errors = 0;

  cordic_vector_iter #(.ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] x;
    logic signed [31:0] y;
    longint             mag;
    longint             mtol;
    longint             ang;
    longint             atol;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    longint d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CORDIC gain over ITER micro-rotations, times optional compensation
  function automatic real kgain();
    real k, p;
    k = 1.0;
    p = 1.0;
    for (int i = 0; i < ITER; i++) begin
      k = k * $sqrt(1.0 + p * p);
      p = p / 2.0;
    end
    return k * POST;
  endfunction

  function automatic longint model_mag(input longint x, input longint y);
    real rx, ry;
    if (x == 0 && y == 0) return 0;
    rx = real'(x);
    ry = real'(y);
    return longint'(kgain() * $sqrt(rx * rx + ry * ry));
  endfunction

  function automatic longint model_ang(input longint x, input longint y);
    if (x == 0 && y == 0) return 0;
    return longint'($atan2(real'(y), real'(x)) * 536870912.0);
  endfunction

  // Launch one transaction and wait (bounded) for done.
  task automatic run_txn(input logic signed [31:0] xv, input logic signed [31:0] yv,
                         output longint mag, output longint ang,
                         output int lat, output int bad);
    bit got;
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    lat = -1;
    bad = 0;
    if (!busy) bad++;
    for (int n = 1; n <= 200 && !got; n++) begin
      tick();
      if (done) begin
        got = 1'b1;
        lat = n;
        if (busy) bad++;
      end else if (!busy) begin
        bad++;
      end
    end
    mag = mag_out;
    ang = angle_out;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint mag, ang, pm, pa, xr, yr;
    int     lat, bad, cnt, d1, d2, d3;
    bit     got;

    tbl[0] = '{32'sd1048576,  32'sd0,        MAG_X1, 64, 0,      32768};
    tbl[1] = '{32'sd1048576,  32'sd1048576,  MAG_XY, 64, A_PI4,  32768};
    tbl[2] = '{-32'sd1048576, 32'sd0,        MAG_X1, 64, A_PI,   32768};
    tbl[3] = '{-32'sd1048576, -32'sd1,       MAG_X1, 64, -A_PI,  32768};
    tbl[4] = '{32'sd0,        32'sd0,        0,      0,  0,      0};
    tbl[5] = '{32'sd0,        -32'sd1048576, MAG_X1, 64, -A_PI2, 32768};

    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0, 0);
    chk("rst_done", done, 0, 0);
    chk("rst_mag", mag_out, 0, 0);
    chk("rst_ang", angle_out, 0, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      run_txn(tbl[k].x, tbl[k].y, mag, ang, lat, bad);
      chk($sformatf("vec%0d_latency", k), lat, LAT, 0);
      chk($sformatf("vec%0d_busy", k), bad, 0, 0);
      chk($sformatf("vec%0d_mag", k), mag, tbl[k].mag, tbl[k].mtol);
      chk($sformatf("vec%0d_ang", k), ang, tbl[k].ang, tbl[k].atol);
    end

    // outputs hold and done stays low after the pulse
    run_txn(32'sd1048576, 32'sd1048576, pm, pa, lat, bad);
    cnt = 0;
    repeat (6) begin
      tick();
      if (done) cnt++;
    end
    chk("hold_done", cnt, 0, 0);
    chk("hold_mag", mag_out, pm, 0);
    chk("hold_ang", angle_out, pa, 0);

    // start re-pulsed while busy with other operands is ignored
    x_in  = 32'sd1048576;
    y_in  = 32'sd1048576;
    start = 1'b1;
    tick();
    start = 1'b0;
    x_in  = -32'sd1048576;
    y_in  = 32'sd0;
    bad = 0;
    if (!busy) bad++;
    repeat (3) begin
      tick();
      if (!busy) bad++;
    end
    start = 1'b1;
    repeat (2) begin
      tick();
      if (!busy) bad++;
    end
    start = 1'b0;
    got = 1'b0;
    lat = -1;
    for (int n = 6; n <= 200 && !got; n++) begin
      tick();
      if (done) begin
        got = 1'b1;
        lat = n;
      end else if (!busy) begin
        bad++;
      end
    end
    chk("repulse_latency", lat, LAT, 0);
    chk("repulse_busy", bad, 0, 0);
    chk("repulse_mag", mag_out, MAG_XY, 64);
    chk("repulse_ang", angle_out, A_PI4, 32768);

    // start held high: back-to-back transactions
    x_in  = 32'sd1048576;
    y_in  = 32'sd1048576;
    start = 1'b1;
    cnt = 0;
    d1 = -1;
    d2 = -1;
    d3 = -1;
    for (int n = 0; n <= 3 * LAT + 3; n++) begin
      tick();
      if (done) begin
        cnt++;
        if (cnt == 1) d1 = n;
        else if (cnt == 2) d2 = n;
        else if (cnt == 3) d3 = n;
        chk($sformatf("b2b_ang%0d", cnt), angle_out, A_PI4, 32768);
      end
    end
    start = 1'b0;
    chk("b2b_count", cnt, 3, 0);
    chk("b2b_first", d1, LAT, 0);
    chk("b2b_period1", d2 - d1, LAT + 1, 0);
    chk("b2b_period2", d3 - d2, LAT + 1, 0);
    repeat (LAT + 3) tick();

    // reset in the middle of a transaction
    x_in  = 32'sd1048576;
    y_in  = 32'sd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", busy, 0, 0);
    chk("midrst_done", done, 0, 0);
    chk("midrst_mag", mag_out, 0, 0);
    chk("midrst_ang", angle_out, 0, 0);
    rst = 1'b0;
    cnt = 0;
    bad = 0;
    repeat (LAT + 4) begin
      tick();
      if (done) cnt++;
      if (busy) bad++;
    end
    chk("midrst_no_done", cnt, 0, 0);
    chk("midrst_idle", bad, 0, 0);
    run_txn(32'sd1048576, 32'sd1048576, mag, ang, lat, bad);
    chk("after_rst_latency", lat, LAT, 0);
    chk("after_rst_mag", mag, MAG_XY, 64);
    chk("after_rst_ang", ang, A_PI4, 32768);

    // random operands against the real-arithmetic model
    for (int k = 0; k < 40; k++) begin
      xr = 0;
      yr = 0;
      for (int t = 0; t < 20 && (xr * xr + yr * yr) < (64'sd1 << 48); t++) begin
        xr = longint'($urandom_range(0, 32'd1 << 30)) - (64'sd1 << 29);
        yr = longint'($urandom_range(0, 32'd1 << 30)) - (64'sd1 << 29);
      end
      run_txn(32'(xr), 32'(yr), mag, ang, lat, bad);
      chk($sformatf("rnd%0d_latency", k), lat, LAT, 0);
      chk($sformatf("rnd%0d_mag", k), mag, model_mag(xr, yr), 128);
      chk($sformatf("rnd%0d_ang", k), ang, model_ang(xr, yr), 32768);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_vector_iter.md
Name: cordic_vector_iter

Overview:
- Iterative vectoring-mode CORDIC engine; the inverse direction of the pipelined rotation stages.
- The rotation stages drive z to zero to rotate a vector. This block drives y to zero and accumulates the angle in z.
- Returns the gain-scaled magnitude and atan2(y, x) for one (x, y) pair per transaction, over a start/busy/done handshake.
- Reuses one shift-add datapath for ITER cycles. Sits beside the rotation pipeline for polar conversion.

Parameters:
- ITER, 16, number of micro-rotations; legal range 1..30; i runs 0..ITER-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x_in  input  32  signed x; |x_in| ≤ 2^29 required.
- y_in  input  32  signed y; |y_in| ≤ 2^29 required.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; results valid on this cycle.
- mag_out  output  32  signed magnitude, gain-scaled unless GAIN_COMP_EN is defined.
- angle_out  output  32  signed angle, Q3.29 radians, range [-pi, +pi].

Behaviour:
- Clock port is clk. Reset port is rst, synchronous and active-high.
- Reset values: busy=0, done=0, mag_out=0, angle_out=0, state=IDLE, iteration counter=0, internal x/y/z=0.
- Reset mid-operation aborts the transaction. No done pulse is produced.
- States and transitions:
  - IDLE: on start=1, latch x_in, y_in, clear z -> PREROT. start is ignored in every other state.
  - PREROT, 1 cycle, x<0 only; otherwise x/y/z pass unchanged:
    - y≥0: x'=y, y'=-x, z'=+pi/2 (0x3243F6A8).
    - y<0: x'=-y, y'=x, z'=-pi/2.
    - Then -> ITERATE with i=0.
  - ITERATE, 1 cycle per i:
    - y<0: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-atan_i.
    - y≥0: x'=x+(y>>>i), y'=y-(x>>>i), z'=z+atan_i.
    - After i=ITER-1 -> DONE (or GAIN when GAIN_COMP_EN is defined).
  - DONE, 1 cycle: register mag_out=x and angle_out=z, assert done=1 and busy=0 -> IDLE.
- Shifts are arithmetic. All add/sub is 32-bit two's complement; the input range guarantees no overflow (gain 1.6468 x √2 < 4).
- atan_i table:
  - Internal constant ROM of 30 entries, round(atan(2^-i)·2^29).
  - atan_0=0x1921FB54, atan_1=0x0ED63383, atan_2=0x07D6DD7E, continuing down.
- Zero vector: if latched x=0 and y=0, DONE outputs mag_out=0 and angle_out=0, regardless of datapath contents.
- Handshake and latency:
  - busy is high from the cycle after the start edge until the done cycle.
  - Latency from the start sample edge to the done edge is ITER+2 cycles.
  - mag_out and angle_out hold their values until the next DONE.
  - start held high continuously: a new transaction begins on the first IDLE cycle after done. Back-to-back throughput is one result per ITER+3 cycles.
- Angle wrap: x<0, y=0 yields approximately +pi (0x6487ED51). -pi is never produced for y=0.

Optional Feature:
- Macro: GAIN_COMP_EN.
- Defined:
  - Extra GAIN state after ITERATE computes mag = (x · 0x4DBA76D4) >>> 31, i.e. K=0.607252935 in Q1.31, using a signed 64-bit product, truncated.
  - Latency becomes ITER+3 cycles.
  - The zero-vector rule still applies.
- Not defined: mag_out is the raw gain-scaled x; latency is ITER+2 cycles.

Test Plan:
- ITER=16, x_in=2^20, y_in=0, start pulse:
  - done exactly 18 cycles later.
  - angle_out within ±2^15 LSB of 0.
  - mag_out = 1726775 ±64 (with GAIN_COMP_EN: 1048576 ±64, at 19 cycles).
- x_in=2^20, y_in=2^20 -> angle_out = 0x1921FB54 ±2^15; mag_out = 2442052 ±64.
- x_in=-2^20, y_in=0 -> angle_out = 0x6487ED51 ±2^15 (positive); x_in=-2^20, y_in=-1 -> angle_out ≈ -pi (0x9B7812AF ±2^15).
- x_in=0, y_in=0 -> done after 18 cycles, mag_out=0, angle_out=0.
- start re-pulsed while busy with different operands -> ignored; results match the first operands; busy stays high throughout.
- rst asserted at cycle 5 of a transaction:
  - next cycle busy=0, done=0, outputs=0, no done pulse.
  - a fresh start afterwards completes correctly in 18 cycles.
